dmem_arbiter: RTL

//  Shares the single-port data memory (dmem) between two requesters: port 0 (CPU load/store) and port 1 (loader/debug master).

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data memory.
// Fixed priority (port 0 wins ties) by default; define DMEM_ARB_RR_EN for round-robin on ties.
module dmem_arbiter #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_w,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_w,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_id,
    output logic          mem_w,
    input  logic [DW-1:0] mem_od,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY0 = 3'd1,
        BUSY1 = 3'd2,
        DONE0 = 3'd3,
        DONE1 = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_id_q, mem_id_d;
    logic          mem_w_q, mem_w_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rd_q, m0_rd_d;
    logic [DW-1:0] m1_rd_q, m1_rd_d;
    logic          busy_q, busy_d;
    logic          any_req_c;
    logic          grant1_c;

`ifdef DMEM_ARB_RR_EN
    logic          last_q, last_d;

    // Tie goes to the port that was not served last; a lone requester always wins.
    always_comb begin
        any_req_c = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant1_c = ~last_q;
        end else begin
            grant1_c = m1_req;
        end
    end
`else
    always_comb begin
        any_req_c = m0_req | m1_req;
        grant1_c  = m1_req & ~m0_req;
    end
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_addr_q <= AW'(0);
            mem_id_q   <= DW'(0);
            mem_w_q    <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rd_q    <= DW'(0);
            m1_rd_q    <= DW'(0);
            busy_q     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_id_q   <= mem_id_d;
            mem_w_q    <= mem_w_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rd_q    <= m0_rd_d;
            m1_rd_q    <= m1_rd_d;
            busy_q     <= busy_d;
`ifdef DMEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d = grant1_c ? BUSY1 : BUSY0;
                end
            end
            BUSY0:   state_d = DONE0;
            BUSY1:   state_d = DONE1;
            DONE0:   state_d = IDLE;
            DONE1:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; the memory bus registers double as the request latch during BUSYx.
    always_comb begin
        mem_addr_d = AW'(0);
        mem_id_d   = DW'(0);
        mem_w_d    = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rd_d    = m0_rd_q;
        m1_rd_d    = m1_rd_q;
        busy_d     = (state_d != IDLE);
`ifdef DMEM_ARB_RR_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    mem_addr_d = grant1_c ? m1_addr : m0_addr;
                    mem_id_d   = grant1_c ? m1_wd   : m0_wd;
                    mem_w_d    = grant1_c ? m1_w    : m0_w;
                end
            end
            BUSY0: begin
                m0_ack_d = 1'b1;
                m0_rd_d  = mem_od;
`ifdef DMEM_ARB_RR_EN
                last_d   = 1'b0;
`endif
            end
            BUSY1: begin
                m1_ack_d = 1'b1;
                m1_rd_d  = mem_od;
`ifdef DMEM_ARB_RR_EN
                last_d   = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign mem_id   = mem_id_q;
    // Gated by rst so a reset edge landing in BUSYx never commits a write.
    assign mem_w    = mem_w_q & rst;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rd    = m0_rd_q;
    assign m1_rd    = m1_rd_q;
    assign busy     = busy_q;

endmodule
